// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a fetch port and a data port.
// One transaction in flight at a time; a hung memory is turned into an error response.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_rdata,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  input  logic        d_req_we,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic        m_req_valid,
  output logic [31:0] m_req_addr,
  output logic [31:0] m_req_wdata,
  output logic [3:0]  m_req_be,
  output logic        m_req_we,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rsp_rdata,
  output logic        fsm_state
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

  state_t      state;
  logic        last_i;
  logic        owner_d;
  logic [15:0] cnt;

  logic idle;
  logic waiting;
  logic grant_i;
  logic grant_d;
  logic expire;
  logic done;
  logic err;

  // Handshake: a request transfers in the cycle where valid and ready are both 1;
  // ready is only offered in IDLE, so at most one transaction is ever outstanding.
  // Every output is forced to 0 while reset is held low.
  assign idle    = reset && (state == IDLE);
  assign waiting = reset && (state == WAIT);

  // On a tie last_i selects data; last_i resets to 1 so data wins the first tie.
  assign grant_i = i_req_valid && (!d_req_valid || !last_i);
  assign grant_d = d_req_valid && (!i_req_valid || last_i);

  assign i_req_ready = idle && grant_i;
  assign d_req_ready = idle && grant_d;

  assign m_req_valid = i_req_ready || d_req_ready;
  assign m_req_addr  = d_req_ready ? d_req_addr  : (i_req_ready ? i_req_addr : 32'h0);
  assign m_req_wdata = d_req_ready ? d_req_wdata : 32'h0;
  assign m_req_be    = d_req_ready ? d_req_be    : (i_req_ready ? 4'hF : 4'h0);
  assign m_req_we    = d_req_ready && d_req_we;

  // cnt holds completed WAIT cycles, so cnt+1 is the length of WAIT including this cycle.
  assign expire = (TIMEOUT_LIM != 17'd0) && (({1'b0, cnt} + 17'd1) >= TIMEOUT_LIM);
  assign done   = waiting && (m_rsp_valid || expire);
  assign err    = !m_rsp_valid && expire;

  assign i_rsp_valid = done && !owner_d;
  assign d_rsp_valid = done && owner_d;
  assign i_rsp_rdata = (i_rsp_valid && m_rsp_valid) ? m_rsp_rdata : 32'h0;
  assign d_rsp_rdata = (d_rsp_valid && m_rsp_valid) ? m_rsp_rdata : 32'h0;
  assign i_rsp_err   = i_rsp_valid && err;
  assign d_rsp_err   = d_rsp_valid && err;

  assign fsm_state = waiting;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last_i  <= 1'b1;
      owner_d <= 1'b0;
      cnt     <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req_valid) begin
            owner_d <= d_req_ready;
            last_i  <= i_req_ready;
            cnt     <= 16'h0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'h1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with TIMEOUT=4, second with TIMEOUT=3
// sharing the same stimulus for the response-versus-expiry race.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_be;
  logic        d_req_we;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;

  logic        i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_rdata;
  logic        d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        m_req_valid, m_req_we, fsm_state;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_be;

  logic        i_req_ready_b, i_rsp_valid_b, i_rsp_err_b;
  logic [31:0] i_rsp_rdata_b;
  logic        d_req_ready_b, d_rsp_valid_b, d_rsp_err_b;
  logic [31:0] d_rsp_rdata_b;
  logic        m_req_valid_b, m_req_we_b, fsm_state_b;
  logic [31:0] m_req_addr_b, m_req_wdata_b;
  logic [3:0]  m_req_be_b;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:255];

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_we(d_req_we),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_req_be(m_req_be), .m_req_we(m_req_we),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .fsm_state(fsm_state)
  );

  mem_arbiter #(.TIMEOUT(3)) dut_b (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_b), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid_b), .i_rsp_rdata(i_rsp_rdata_b), .i_rsp_err(i_rsp_err_b),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_b), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_we(d_req_we),
    .d_rsp_valid(d_rsp_valid_b), .d_rsp_rdata(d_rsp_rdata_b), .d_rsp_err(d_rsp_err_b),
    .m_req_valid(m_req_valid_b), .m_req_addr(m_req_addr_b), .m_req_wdata(m_req_wdata_b),
    .m_req_be(m_req_be_b), .m_req_we(m_req_we_b),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .fsm_state(fsm_state_b)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = 32'h0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    cyc();
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    quiet();
    i_req_addr  = 32'h0;
    d_req_addr  = 32'h0;
    d_req_wdata = 32'h0;
    d_req_be    = 4'h0;
    reset       = 1'b0;

    // outputs held at 0 during reset even with both requesters valid
    #2;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    chk("rst_i_ready", {31'h0, i_req_ready}, 32'h0);
    chk("rst_d_ready", {31'h0, d_req_ready}, 32'h0);
    chk("rst_m_valid", {31'h0, m_req_valid}, 32'h0);
    chk("rst_m_be", {28'h0, m_req_be}, 32'h0);
    chk("rst_state", {31'h0, fsm_state}, 32'h0);
    quiet();
    cyc();
    reset = 1'b1;
    cyc();

    // single data read
    d_req_valid = 1'b1;
    d_req_addr  = 32'h100;
    #3;
    chk("rd_d_ready", {31'h0, d_req_ready}, 32'h1);
    chk("rd_i_ready", {31'h0, i_req_ready}, 32'h0);
    chk("rd_m_addr", m_req_addr, 32'h100);
    chk("rd_m_we", {31'h0, m_req_we}, 32'h0);
    cyc();
    d_req_valid = 1'b0;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'hDEADBEEF;
    #3;
    chk("rd_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    chk("rd_d_rsp_rdata", d_rsp_rdata, 32'hDEADBEEF);
    chk("rd_d_rsp_err", {31'h0, d_rsp_err}, 32'h0);
    chk("rd_i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
    chk("rd_m_valid_wait", {31'h0, m_req_valid}, 32'h0);
    cyc();
    quiet();
    #3;
    chk("rd_after_valid", {31'h0, d_rsp_valid}, 32'h0);

    // fairness: both continuously valid, grants D,I,D,I,... one per 2 cycles
    do_reset();
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_req_addr = 32'h200 + 32'(k * 4);
      d_req_addr = 32'h300 + 32'(k * 4);
      #3;
      chk("rr_d_ready", {31'h0, d_req_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_i_ready", {31'h0, i_req_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_m_addr", m_req_addr, (k % 2 == 0) ? 32'h300 + 32'(k * 4) : 32'h200 + 32'(k * 4));
      cyc();
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 32'hA0000000 + 32'(k);
      #3;
      chk("rr_wait_readies", {30'h0, i_req_ready, d_req_ready}, 32'h0);
      chk("rr_d_rsp_valid", {31'h0, d_rsp_valid}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_i_rsp_valid", {31'h0, i_rsp_valid}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_rsp_rdata", d_rsp_rdata | i_rsp_rdata, 32'hA0000000 + 32'(k));
      cyc();
      m_rsp_valid = 1'b0;
    end
    quiet();
    cyc();

    // data write then read-back on a zeroed memory
    d_req_valid = 1'b1;
    d_req_addr  = 32'h40;
    d_req_wdata = 32'h12345678;
    d_req_be    = 4'b0011;
    d_req_we    = 1'b1;
    #3;
    chk("wr_m_valid", {31'h0, m_req_valid}, 32'h1);
    chk("wr_m_addr", m_req_addr, 32'h40);
    chk("wr_m_wdata", m_req_wdata, 32'h12345678);
    chk("wr_m_be", {28'h0, m_req_be}, 32'h3);
    chk("wr_m_we", {31'h0, m_req_we}, 32'h1);
    mem_write(32'h40, 32'h12345678, 4'b0011);
    cyc();
    quiet();
    m_rsp_valid = 1'b1;
    #3;
    chk("wr_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    chk("wr_d_rsp_rdata", d_rsp_rdata, 32'h0);
    cyc();
    quiet();
    d_req_valid = 1'b1;
    d_req_addr  = 32'h40;
    #3;
    chk("rb_d_ready", {31'h0, d_req_ready}, 32'h1);
    cyc();
    quiet();
    m_rsp_valid = 1'b1;
    m_rsp_rdata = mem[8'h10];
    #3;
    chk("rb_d_rsp_rdata", d_rsp_rdata, 32'h00005678);
    cyc();
    quiet();

    // fetch timeout (TIMEOUT=4): error at N+4, late response at N+6 dropped
    i_req_valid = 1'b1;
    i_req_addr  = 32'h80;
    #3;
    chk("to_i_ready", {31'h0, i_req_ready}, 32'h1);
    chk("to_m_be", {28'h0, m_req_be}, 32'hF);
    chk("to_m_wdata", m_req_wdata, 32'h0);
    for (int t = 1; t < 4; t++) begin
      cyc();
      i_req_valid = 1'b0;
      #3;
      chk("to_early_valid", {31'h0, i_rsp_valid}, 32'h0);
    end
    cyc();
    #3;
    chk("to_i_rsp_valid", {31'h0, i_rsp_valid}, 32'h1);
    chk("to_i_rsp_err", {31'h0, i_rsp_err}, 32'h1);
    chk("to_i_rsp_rdata", i_rsp_rdata, 32'h0);
    cyc();
    #3;
    chk("to_idle_n5", {31'h0, fsm_state}, 32'h0);
    cyc();
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'h55555555;
    #3;
    chk("late_i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
    chk("late_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    cyc();
    quiet();

    // second timeout: a new grant is taken at N+5
    i_req_valid = 1'b1;
    cyc();
    i_req_valid = 1'b0;
    repeat (4) cyc();
    d_req_valid = 1'b1;
    d_req_addr  = 32'h44;
    #3;
    chk("to_regrant_n5", {31'h0, d_req_ready}, 32'h1);
    cyc();
    quiet();
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'h77;
    #3;
    chk("to_regrant_rsp", d_rsp_rdata, 32'h77);
    cyc();
    quiet();

    // response and expiry in the same cycle on the TIMEOUT=3 instance
    d_req_valid = 1'b1;
    d_req_addr  = 32'h48;
    #3;
    chk("race_grant", {31'h0, d_req_ready_b}, 32'h1);
    cyc();
    quiet();
    cyc();
    #3;
    chk("race_early", {31'h0, d_rsp_valid_b}, 32'h0);
    cyc();
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'hCAFE0001;
    #3;
    chk("race_valid", {31'h0, d_rsp_valid_b}, 32'h1);
    chk("race_err", {31'h0, d_rsp_err_b}, 32'h0);
    chk("race_rdata", d_rsp_rdata_b, 32'hCAFE0001);
    cyc();
    quiet();

    // reset in the middle of WAIT after a fetch grant
    i_req_valid = 1'b1;
    #3;
    chk("mr_i_grant", {31'h0, i_req_ready}, 32'h1);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    reset       = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    chk("mr_state", {31'h0, fsm_state}, 32'h0);
    chk("mr_i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
    chk("mr_readies", {30'h0, i_req_ready, d_req_ready}, 32'h0);
    chk("mr_m_valid", {31'h0, m_req_valid}, 32'h0);
    quiet();
    #2;
    reset = 1'b1;
    cyc();
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'h99;
    #3;
    chk("mr_drop_i", {31'h0, i_rsp_valid}, 32'h0);
    chk("mr_drop_d", {31'h0, d_rsp_valid}, 32'h0);
    cyc();
    quiet();
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #3;
    chk("mr_tie_d", {31'h0, d_req_ready}, 32'h1);
    chk("mr_tie_i", {31'h0, i_req_ready}, 32'h0);
    cyc();
    quiet();
    m_rsp_valid = 1'b1;
    cyc();
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
